// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - registered multi-cycle MEM stage bus master with MMIO decode and timeout
module mem_access_unit #(
  parameter logic [31:0] IO_MASK   = 32'hFFFF_F000,
  parameter logic [31:0] IO_BASE   = 32'hFFFF_F000,
  parameter int unsigned MAX_WAIT  = 16,
  parameter bit          LITTLE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  aluop_i,
  input  logic [4:0]  wregaddr_i,
  input  logic        wregenb_i,
  input  logic [31:0] wregdata_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wrdata_i,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic        mem_io_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_data_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_data_i,
  output logic        wb_valid_o,
  output logic [4:0]  wregaddr_o,
  output logic        wregenb_o,
  output logic [31:0] wregdata_o,
  output logic        misalign_o,
  output logic        bus_err_o,
  output logic [31:0] badvaddr_o
);
  localparam logic [7:0] OP_LB  = 8'hE0, OP_LH  = 8'hE1, OP_LW = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4, OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8, OP_SH  = 8'hE9, OP_SW = 8'hEB;
  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 2);

  typedef enum logic {IDLE, BUSY} state_t;
  // sz: 0 byte, 1 half, 2 word
  typedef struct packed {logic mem; logic ld; logic [1:0] sz; logic uns;} dec_t;

  function automatic dec_t decode(input logic [7:0] op);
    case (op)
      OP_LB:   return 5'b1_1_00_0;
      OP_LBU:  return 5'b1_1_00_1;
      OP_LH:   return 5'b1_1_01_0;
      OP_LHU:  return 5'b1_1_01_1;
      OP_LW:   return 5'b1_1_10_0;
      OP_SB:   return 5'b1_0_00_0;
      OP_SH:   return 5'b1_0_01_0;
      OP_SW:   return 5'b1_0_10_0;
      default: return 5'b0_0_00_0;
    endcase
  endfunction

  function automatic logic [1:0] byte_lane(input logic [1:0] a);
    return LITTLE_EN ? a : ~a;
  endfunction

  function automatic logic [1:0] half_lane(input logic a1);
    return {LITTLE_EN ? a1 : ~a1, 1'b0};
  endfunction

  state_t        state, state_n;
  logic [CW-1:0] wait_cnt, cnt_n;
  logic          ld_q, ld_n, uns_q, uns_n, sv_enb_q, sv_enb_n;
  logic [1:0]    sz_q, sz_n;
  logic [4:0]    sv_addr_q, sv_addr_n;
  logic [31:0]   vaddr_q, vaddr_n;
  logic          req_n, we_n, io_n, wbv_n, wenb_n, mis_n, berr_n;
  logic [3:0]    be_n, be_in;
  logic [31:0]   maddr_n, mdata_n, wdata_n, bad_n, data_in, ld_data;
  logic [4:0]    waddr_n, bsel, hsel;
  logic          misaligned;
  dec_t          dec_in;

  assign stall_o = (state == BUSY);
  assign dec_in  = decode(aluop_i);
  assign bsel    = {byte_lane(vaddr_q[1:0]), 3'b000};
  assign hsel    = {half_lane(vaddr_q[1]), 3'b000};

  always_comb begin
    misaligned = ((dec_in.sz == 2'd1) && mem_addr_i[0]) ||
                 ((dec_in.sz == 2'd2) && (mem_addr_i[1:0] != 2'b00));
    case (dec_in.sz)
      2'd0:    begin be_in = 4'b0001 << byte_lane(mem_addr_i[1:0]); data_in = {4{mem_wrdata_i[7:0]}};  end
      2'd1:    begin be_in = 4'b0011 << half_lane(mem_addr_i[1]);    data_in = {2{mem_wrdata_i[15:0]}}; end
      default: begin be_in = 4'hF;                                   data_in = mem_wrdata_i;            end
    endcase
    case (sz_q)
      2'd0:    ld_data = {{24{~uns_q & mem_data_i[bsel+7]}},  mem_data_i[bsel +: 8]};
      2'd1:    ld_data = {{16{~uns_q & mem_data_i[hsel+15]}}, mem_data_i[hsel +: 16]};
      default: ld_data = mem_data_i;
    endcase
  end

  always_comb begin
    state_n   = state;       cnt_n    = wait_cnt;
    ld_n      = ld_q;        uns_n    = uns_q;      sz_n     = sz_q;
    sv_addr_n = sv_addr_q;   sv_enb_n = sv_enb_q;   vaddr_n  = vaddr_q;
    req_n     = mem_req_o;   we_n     = mem_we_o;   io_n     = mem_io_o;
    be_n      = mem_be_o;    maddr_n  = mem_addr_o; mdata_n  = mem_data_o;
    wbv_n     = 1'b0;        wenb_n   = 1'b0;
    waddr_n   = wregaddr_o;  wdata_n  = wregdata_o;
    mis_n     = 1'b0;        berr_n   = 1'b0;       bad_n    = badvaddr_o;
    case (state)
      IDLE: if (valid_i) begin
        if (!dec_in.mem) begin
          wbv_n   = 1'b1;       wenb_n  = wregenb_i;
          waddr_n = wregaddr_i; wdata_n = wregdata_i;
        end else if (misaligned) begin
          mis_n = 1'b1;
          bad_n = mem_addr_i;
        end else begin
          state_n   = BUSY;        cnt_n    = '0;
          req_n     = 1'b1;        we_n     = ~dec_in.ld;
          io_n      = ((mem_addr_i & IO_MASK) == IO_BASE);
          be_n      = be_in;       mdata_n  = data_in;
          maddr_n   = {mem_addr_i[31:2], 2'b00};
          ld_n      = dec_in.ld;   uns_n    = dec_in.uns;  sz_n = dec_in.sz;
          sv_addr_n = wregaddr_i;  sv_enb_n = wregenb_i;   vaddr_n = mem_addr_i;
        end
      end
      BUSY: if (mem_ack_i) begin
        // ack has priority over a timeout landing on the same edge
        state_n = IDLE;      cnt_n   = '0;   req_n = 1'b0;
        wbv_n   = 1'b1;      waddr_n = sv_addr_q;
        wenb_n  = ld_q & sv_enb_q;
        if (ld_q) wdata_n = ld_data;
      end else if (wait_cnt == WAIT_LAST) begin
        state_n = IDLE;      cnt_n   = '0;   req_n = 1'b0;
        berr_n  = 1'b1;      bad_n   = vaddr_q;
      end else begin
        cnt_n = wait_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;  wait_cnt  <= '0;
      ld_q      <= 1'b0;  uns_q     <= 1'b0;  sz_q     <= 2'd0;
      sv_addr_q <= '0;    sv_enb_q  <= 1'b0;  vaddr_q  <= '0;
      mem_req_o <= 1'b0;  mem_we_o  <= 1'b0;  mem_io_o <= 1'b0;
      mem_be_o  <= '0;    mem_addr_o <= '0;   mem_data_o <= '0;
      wb_valid_o <= 1'b0; wregenb_o <= 1'b0;  wregaddr_o <= '0; wregdata_o <= '0;
      misalign_o <= 1'b0; bus_err_o <= 1'b0;  badvaddr_o <= '0;
    end else begin
      state     <= state_n;  wait_cnt  <= cnt_n;
      ld_q      <= ld_n;     uns_q     <= uns_n;    sz_q     <= sz_n;
      sv_addr_q <= sv_addr_n; sv_enb_q <= sv_enb_n; vaddr_q  <= vaddr_n;
      mem_req_o <= req_n;    mem_we_o  <= we_n;     mem_io_o <= io_n;
      mem_be_o  <= be_n;     mem_addr_o <= maddr_n; mem_data_o <= mdata_n;
      wb_valid_o <= wbv_n;   wregenb_o <= wenb_n;   wregaddr_o <= waddr_n; wregdata_o <= wdata_n;
      misalign_o <= mis_n;   bus_err_o <= berr_n;   badvaddr_o <= bad_n;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - randomized self-checking bench for mem_access_unit
module tb_mem_access_unit;
  localparam int          MAX_WAIT = 16;
  localparam bit          LE       = 1'b1;
  localparam logic [31:0] IO_MASK  = 32'hFFFF_F000;
  localparam logic [31:0] IO_BASE  = 32'hFFFF_F000;
  localparam logic [7:0] OP_LB  = 8'hE0, OP_LH  = 8'hE1, OP_LW = 8'hE3;
  localparam logic [7:0] OP_LBU = 8'hE4, OP_LHU = 8'hE5;
  localparam logic [7:0] OP_SB  = 8'hE8, OP_SH  = 8'hE9, OP_SW = 8'hEB;

  logic        clk = 1'b0, rst = 1'b0;
  logic        valid_i = 1'b0, wregenb_i = 1'b0, mem_ack_i = 1'b0;
  logic [7:0]  aluop_i = '0;
  logic [4:0]  wregaddr_i = '0;
  logic [31:0] wregdata_i = '0, mem_addr_i = '0, mem_wrdata_i = '0, mem_data_i = '0;
  logic        stall_o, mem_req_o, mem_we_o, mem_io_o, wb_valid_o, wregenb_o, misalign_o, bus_err_o;
  logic [3:0]  mem_be_o;
  logic [4:0]  wregaddr_o;
  logic [31:0] mem_addr_o, mem_data_o, wregdata_o, badvaddr_o;

  int checks = 0, errors = 0;
  int cap_req;
  logic [3:0]  cap_be;
  logic [31:0] cap_mdata, cap_wdata;
  logic        cap_io;

  mem_access_unit #(.IO_MASK(IO_MASK), .IO_BASE(IO_BASE), .MAX_WAIT(MAX_WAIT), .LITTLE_EN(LE)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .aluop_i(aluop_i), .wregaddr_i(wregaddr_i),
    .wregenb_i(wregenb_i), .wregdata_i(wregdata_i), .mem_addr_i(mem_addr_i),
    .mem_wrdata_i(mem_wrdata_i), .stall_o(stall_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_io_o(mem_io_o), .mem_be_o(mem_be_o), .mem_addr_o(mem_addr_o), .mem_data_o(mem_data_o),
    .mem_ack_i(mem_ack_i), .mem_data_i(mem_data_i), .wb_valid_o(wb_valid_o),
    .wregaddr_o(wregaddr_o), .wregenb_o(wregenb_o), .wregdata_o(wregdata_o),
    .misalign_o(misalign_o), .bus_err_o(bus_err_o), .badvaddr_o(badvaddr_o));

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int op_bytes(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 1;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LW, OP_SW:         return 4;
      default:              return 0;
    endcase
  endfunction

  function automatic bit op_load(input logic [7:0] op);
    return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW};
  endfunction

  function automatic int lane_of(input logic [31:0] b);
    return LE ? int'(b[1:0]) : 3 - int'(b[1:0]);
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input int n);
    logic [3:0] be = '0;
    for (int i = 0; i < n; i++) be |= 4'b0001 << lane_of(a + i);
    return be;
  endfunction

  // assemble the loaded value byte by byte from the bus word
  function automatic logic [31:0] exp_load(input logic [7:0] op, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v = '0, byt;
    int n = op_bytes(op);
    for (int i = 0; i < n; i++) begin
      byt = (rd >> (8 * lane_of(a + i))) & 32'hFF;
      v |= byt << (LE ? 8 * i : 8 * (n - 1 - i));
    end
    if (n < 4 && !(op inside {OP_LBU, OP_LHU}) && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
    return v;
  endfunction

  function automatic logic [31:0] exp_sdata(input int n, input logic [31:0] w);
    if (n == 1) return {4{w[7:0]}};
    if (n == 2) return {2{w[15:0]}};
    return w;
  endfunction

  task automatic idle_cycle(input bit stray_ack);
    mem_ack_i  = stray_ack;
    mem_data_i = $urandom;
    @(posedge clk); #1;
    mem_ack_i = 1'b0;
    check_eq("idle_wbv",  wb_valid_o, 0);
    check_eq("idle_wenb", wregenb_o, 0);
    check_eq("idle_pulse", {misalign_o, bus_err_o, mem_req_o, stall_o}, 0);
  endtask

  // ack_at: BUSY cycle (1-based) in which ack is driven; 0 = never
  task automatic do_op(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [31:0] rd, input int ack_at, input logic [4:0] wa,
                       input logic wen, input logic [31:0] alu);
    int n = op_bytes(op);
    valid_i = 1'b1; aluop_i = op; mem_addr_i = addr; mem_wrdata_i = wd;
    wregaddr_i = wa; wregenb_i = wen; wregdata_i = alu;
    @(posedge clk); #1;
    valid_i = 1'b0;
    cap_req = 0;
    if (n == 0) begin
      check_eq("alu_wbv",  wb_valid_o, 1);
      check_eq("alu_wenb", wregenb_o, wen);
      check_eq("alu_wa",   wregaddr_o, wa);
      check_eq("alu_wd",   wregdata_o, alu);
      check_eq("alu_stall", stall_o, 0);
    end else if ((addr % n) != 0) begin
      check_eq("mis_pulse", misalign_o, 1);
      check_eq("mis_bad",   badvaddr_o, addr);
      check_eq("mis_wb",    {wb_valid_o, wregenb_o}, 0);
      check_eq("mis_noreq", {mem_req_o, stall_o}, 0);
    end else begin
      cap_be = mem_be_o; cap_mdata = mem_data_o; cap_io = mem_io_o;
      check_eq("req",   {mem_req_o, stall_o}, 2'b11);
      check_eq("we",    mem_we_o, !op_load(op));
      check_eq("io",    mem_io_o, (addr & IO_MASK) == IO_BASE);
      check_eq("be",    mem_be_o, exp_be(addr, n));
      check_eq("maddr", mem_addr_o, {addr[31:2], 2'b00});
      if (!op_load(op)) check_eq("mdata", mem_data_o, exp_sdata(n, wd));
      for (int k = 1; k <= MAX_WAIT; k++) begin
        cap_req    = k;
        mem_ack_i  = (k == ack_at);
        mem_data_i = rd;
        @(posedge clk); #1;
        mem_ack_i = 1'b0;
        if (k == ack_at) begin
          cap_wdata = wregdata_o;
          check_eq("ack_done", {mem_req_o, stall_o, bus_err_o}, 0);
          check_eq("ack_wbv",  wb_valid_o, 1);
          check_eq("ack_wenb", wregenb_o, op_load(op) ? wen : 1'b0);
          if (op_load(op)) begin
            check_eq("ld_wa",   wregaddr_o, wa);
            check_eq("ld_data", wregdata_o, exp_load(op, addr, rd));
          end
          break;
        end else if (k == MAX_WAIT - 1) begin
          check_eq("to_err",  bus_err_o, 1);
          check_eq("to_bad",  badvaddr_o, addr);
          check_eq("to_rel",  {mem_req_o, stall_o, wb_valid_o}, 0);
          break;
        end else begin
          check_eq("busy_hold", {mem_req_o, stall_o, mem_be_o, bus_err_o}, {2'b11, exp_be(addr, n), 1'b0});
        end
      end
    end
    idle_cycle($urandom_range(0, 1) == 1);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ctl",  {stall_o, mem_req_o, mem_we_o, mem_io_o, mem_be_o}, 0);
    check_eq("rst_wb",   {wb_valid_o, wregenb_o, wregaddr_o, misalign_o, bus_err_o}, 0);
    check_eq("rst_data", mem_addr_o | mem_data_o | wregdata_o | badvaddr_o, 0);
    rst = 1'b1;
    idle_cycle(1'b1);

    do_op(OP_LW, 32'h0000_0010, 32'h0, 32'hDEAD_BEEF, 1, 5'd3, 1'b1, 32'h0);
    check_eq("d_lw_data", cap_wdata, 32'hDEAD_BEEF);
    check_eq("d_lw_req",  cap_req, 1);
    check_eq("d_lw_be",   cap_be, 4'hF);
    do_op(OP_LB, 32'h13, 32'h0, 32'h80FF_0000, 2, 5'd4, 1'b1, 32'h0);
    check_eq("d_lb",  cap_wdata, 32'hFFFF_FF80);
    do_op(OP_LBU, 32'h13, 32'h0, 32'h80FF_0000, 1, 5'd4, 1'b1, 32'h0);
    check_eq("d_lbu", cap_wdata, 32'h0000_0080);
    do_op(OP_SH, 32'hFFFF_F002, 32'h1234_ABCD, 32'h0, 3, 5'd5, 1'b1, 32'h0);
    check_eq("d_sh_io",   cap_io, 1);
    check_eq("d_sh_be",   cap_be, 4'b1100);
    check_eq("d_sh_data", cap_mdata, 32'hABCD_ABCD);
    do_op(OP_LH, 32'h0000_0001, 32'h0, 32'h0, 1, 5'd6, 1'b1, 32'h0);
    do_op(OP_LW, 32'h0000_0020, 32'h0, 32'h0, 0, 5'd7, 1'b1, 32'h0);
    check_eq("d_to_req", cap_req, MAX_WAIT - 1);
    do_op(OP_LHU, 32'h0000_0042, 32'h0, 32'hBEEF_1234, MAX_WAIT - 1, 5'd8, 1'b1, 32'h0);
    check_eq("d_edge_ack", cap_wdata, 32'h0000_BEEF);
    do_op(8'h21, 32'h0, 32'h0, 32'h0, 0, 5'd9, 1'b1, 32'hCAFE_F00D);

    // reset while a load is outstanding, then a late ack
    valid_i = 1'b1; aluop_i = OP_LW; mem_addr_i = 32'h100; wregenb_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    check_eq("rb_req", mem_req_o, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("rb_drop", {mem_req_o, stall_o, wb_valid_o, bus_err_o, misalign_o}, 0);
    rst = 1'b1;
    idle_cycle(1'b1);

    for (int t = 0; t < 80; t++) begin
      logic [7:0]  op;
      logic [31:0] a;
      int          sel, ack;
      sel = $urandom_range(0, 8);
      case (sel)
        0: op = OP_LB;  1: op = OP_LBU; 2: op = OP_LH; 3: op = OP_LHU; 4: op = OP_LW;
        5: op = OP_SB;  6: op = OP_SH;  7: op = OP_SW;
        default: op = 8'($urandom_range(0, 31));
      endcase
      a = $urandom;
      if ($urandom_range(0, 3) == 0) a = {20'hFFFFF, a[11:0]};
      if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
      ack = $urandom_range(0, 6) == 0 ? 0 : $urandom_range(1, MAX_WAIT - 1);
      do_op(op, a, $urandom, $urandom, ack, 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
